ui_input_conditioner: RTL and testbench

- Parametrised multi-channel front-panel input conditioner. Replaces the per-signal trigger-smoother instances (music keys, PlaySong0/1, MakeRecording, PlayRecording) with a single bank.
- Per channel: 2-FF synchronisation, debounce, clean level, press/release event pulses, long-press detection with optional auto-repeat.
- Sits between the raw GPIO pins and the state controller / music-keys controller.

---
 rtl/ui_input_pkg.sv | 21 ++
 rtl/ui_input_channel.sv | 166 ++++++++++++++++
 rtl/ui_input_conditioner.sv | 44 ++++
 tb/tb_ui_input_conditioner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ui_input_pkg.sv
// Shared types and 50 MHz timing defaults for the front-panel input conditioner.
package ui_input_pkg;

    typedef enum logic [2:0] {
        ST_RELEASED,
        ST_CONFIRM_PRESS,
        ST_PRESSED,
        ST_HELD,
        ST_CONFIRM_RELEASE
    } chan_state_e;

    localparam int DEFAULT_SYNC_STAGES   = 2;
    localparam int DEFAULT_SETTLE_CYCLES = 50_000;      // 1 ms at 50 MHz
    localparam int DEFAULT_HOLD_CYCLES   = 50_000_000;  // 1 s at 50 MHz

    // Counter width able to hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ui_input_channel.sv
// One input channel: synchroniser, debounce FSM, press/release/held event pulses.
module ui_input_channel
    import ui_input_pkg::*;
#(
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = 0,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_enable,
    output logic o_level,
    output logic o_pressed,
    output logic o_released,
    output logic o_held
);

    localparam int SW = cnt_width(SETTLE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int RW = cnt_width(REPEAT_CYCLES);

    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_ONE = SW'(1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] REP_MAX    = RW'(REPEAT_CYCLES);

    localparam logic                   INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [SYNC_STAGES-1:0] SYNC_RST = {SYNC_STAGES{INACTIVE}};

    logic [SYNC_STAGES-1:0] r_sync;
    chan_state_e            r_state;
    logic [SW-1:0]          r_settle_cnt;
    logic [HW-1:0]          r_hold_cnt;
    logic [RW-1:0]          r_rep_cnt;
    logic                   r_from_held;
    logic                   r_level;
    logic                   r_pressed;
    logic                   r_released;
    logic                   r_held;

    logic                   w_act;
    logic [SW-1:0]          w_settle_inc;
    logic [HW-1:0]          w_hold_inc;
    logic [RW-1:0]          w_rep_inc;

    // The sync chain is outside the enable so a re-enabled channel sees the live pin.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= SYNC_RST;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_act = r_sync[SYNC_STAGES-1] ^ INACTIVE;

    assign w_settle_inc = (r_settle_cnt == SETTLE_MAX) ? r_settle_cnt : r_settle_cnt + SW'(1);
    assign w_hold_inc   = (r_hold_cnt == HOLD_MAX)     ? r_hold_cnt   : r_hold_cnt + HW'(1);
    assign w_rep_inc    = (r_rep_cnt == REP_MAX)       ? r_rep_cnt    : r_rep_cnt + RW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_RELEASED;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
            r_rep_cnt    <= '0;
            r_from_held  <= 1'b0;
            r_level      <= 1'b0;
            r_pressed    <= 1'b0;
            r_released   <= 1'b0;
            r_held       <= 1'b0;
        end else begin
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            r_held     <= 1'b0;
            if (!i_enable) begin
                r_state      <= ST_RELEASED;
                r_settle_cnt <= '0;
                r_hold_cnt   <= '0;
                r_rep_cnt    <= '0;
                r_from_held  <= 1'b0;
                r_level      <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_RELEASED: begin
                        if (w_act) begin
                            r_state      <= ST_CONFIRM_PRESS;
                            r_settle_cnt <= SETTLE_ONE;
                        end
                    end
                    ST_CONFIRM_PRESS: begin
                        if (!w_act) begin
                            r_state      <= ST_RELEASED;
                            r_settle_cnt <= '0;
                        end else if (r_settle_cnt == SETTLE_MAX) begin
                            r_state      <= ST_PRESSED;
                            r_settle_cnt <= '0;
                            r_hold_cnt   <= '0;
                            r_level      <= 1'b1;
                            r_pressed    <= 1'b1;
                        end else begin
                            r_settle_cnt <= w_settle_inc;
                        end
                    end
                    ST_PRESSED: begin
                        if (!w_act) begin
                            r_state      <= ST_CONFIRM_RELEASE;
                            r_settle_cnt <= SETTLE_ONE;
                            r_from_held  <= 1'b0;
                        end else begin
                            r_hold_cnt <= w_hold_inc;
                            if (w_hold_inc == HOLD_MAX) begin
                                r_state   <= ST_HELD;
                                r_rep_cnt <= '0;
                                r_held    <= 1'b1;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (!w_act) begin
                            r_state      <= ST_CONFIRM_RELEASE;
                            r_settle_cnt <= SETTLE_ONE;
                            r_from_held  <= 1'b1;
                        end else if (REPEAT_CYCLES > 0) begin
                            if (w_rep_inc == REP_MAX) begin
                                r_rep_cnt <= '0;
                                r_held    <= 1'b1;
                            end else begin
                                r_rep_cnt <= w_rep_inc;
                            end
                        end
                    end
                    ST_CONFIRM_RELEASE: begin
                        // Hold and repeat counters stay frozen here and resume on return.
                        if (w_act) begin
                            r_state      <= r_from_held ? ST_HELD : ST_PRESSED;
                            r_settle_cnt <= '0;
                        end else if (r_settle_cnt == SETTLE_MAX) begin
                            r_state      <= ST_RELEASED;
                            r_settle_cnt <= '0;
                            r_hold_cnt   <= '0;
                            r_rep_cnt    <= '0;
                            r_level      <= 1'b0;
                            r_released   <= 1'b1;
                        end else begin
                            r_settle_cnt <= w_settle_inc;
                        end
                    end
                    default: begin
                        r_state      <= ST_RELEASED;
                        r_settle_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign o_level    = r_level;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    assign o_held     = r_held;

endmodule

// File: rtl/ui_input_conditioner.sv
// Bank of independent debounced input channels for the front-panel buttons and keys.
module ui_input_conditioner
    import ui_input_pkg::*;
#(
    parameter int NUM_CHANNELS  = 10,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = 0,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset_n,
    input  logic [NUM_CHANNELS-1:0] inputRaw,
    input  logic [NUM_CHANNELS-1:0] channelEnable,
    output logic [NUM_CHANNELS-1:0] outputLevel,
    output logic [NUM_CHANNELS-1:0] outputPressed,
    output logic [NUM_CHANNELS-1:0] outputReleased,
    output logic [NUM_CHANNELS-1:0] outputHeld,
    output logic                    anyPressed
);

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        ui_input_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .SETTLE_CYCLES(SETTLE_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .i_clk     (clock_50Mhz),
            .i_rst_n   (reset_n),
            .i_raw     (inputRaw[g]),
            .i_enable  (channelEnable[g]),
            .o_level   (outputLevel[g]),
            .o_pressed (outputPressed[g]),
            .o_released(outputReleased[g]),
            .o_held    (outputHeld[g])
        );
    end

    assign anyPressed = |outputLevel;

endmodule

// File: tb/tb_ui_input_conditioner.sv
// Directed vector bench: one DUT with auto-repeat, one with repeat disabled, same stimulus.
module tb_ui_input_conditioner;

    localparam int NCH = 10;
    localparam logic [NCH-1:0] ALL = '1;

    typedef struct {
        logic [NCH-1:0] raw;
        logic [NCH-1:0] en;
        int             adv;
        logic [NCH-1:0] lvl;
        logic [NCH-1:0] prs;
        logic [NCH-1:0] rel;
        logic [NCH-1:0] hld;
        logic [NCH-1:0] hld_nr;
        bit             rst;
    } vec_t;

    logic           clk;
    logic           rst_n;
    logic [NCH-1:0] raw;
    logic [NCH-1:0] en;
    logic [NCH-1:0] lvl_a, prs_a, rel_a, hld_a;
    logic           any_a;
    logic [NCH-1:0] lvl_b, prs_b, rel_b, hld_b;
    logic           any_b;

    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    logic [NCH-1:0] prev_lvl;
    logic [NCH-1:0] exp_q[$];
    vec_t           vecs[$];

    ui_input_conditioner #(
        .NUM_CHANNELS(NCH), .SYNC_STAGES(2), .SETTLE_CYCLES(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1)
    ) u_dut (
        .clock_50Mhz   (clk),
        .reset_n       (rst_n),
        .inputRaw      (raw),
        .channelEnable (en),
        .outputLevel   (lvl_a),
        .outputPressed (prs_a),
        .outputReleased(rel_a),
        .outputHeld    (hld_a),
        .anyPressed    (any_a)
    );

    ui_input_conditioner #(
        .NUM_CHANNELS(NCH), .SYNC_STAGES(2), .SETTLE_CYCLES(4),
        .HOLD_CYCLES(20), .REPEAT_CYCLES(0), .ACTIVE_LOW(1)
    ) u_dut_norep (
        .clock_50Mhz   (clk),
        .reset_n       (rst_n),
        .inputRaw      (raw),
        .channelEnable (en),
        .outputLevel   (lvl_b),
        .outputPressed (prs_b),
        .outputReleased(rel_b),
        .outputHeld    (hld_b),
        .anyPressed    (any_b)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard
    task automatic check(input string name, input int idx, input logic [NCH-1:0] got,
                         input logic [NCH-1:0] exp);
        logic [NCH-1:0] e;
        exp_q.push_back(exp);
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s vec=%0d cyc=%0d got=%h exp=%h", name, idx, cyc, got, e);
        end
    endtask

    task automatic compare_outputs(input int idx, input logic [NCH-1:0] e_lvl,
                                   input logic [NCH-1:0] e_prs, input logic [NCH-1:0] e_rel,
                                   input logic [NCH-1:0] e_hld, input logic [NCH-1:0] e_hld_nr);
        check("level",       idx, lvl_a, e_lvl);
        check("pressed",     idx, prs_a, e_prs);
        check("released",    idx, rel_a, e_rel);
        check("held",        idx, hld_a, e_hld);
        check("any",         idx, {{(NCH-1){1'b0}}, any_a}, {{(NCH-1){1'b0}}, |e_lvl});
        check("nr_level",    idx, lvl_b, e_lvl);
        check("nr_pressed",  idx, prs_b, e_prs);
        check("nr_released", idx, rel_b, e_rel);
        check("nr_held",     idx, hld_b, e_hld_nr);
        check("nr_any",      idx, {{(NCH-1){1'b0}}, any_b}, {{(NCH-1){1'b0}}, |e_lvl});
    endtask

    // Driver: optional async reset, apply inputs, then every edge until the checkpoint
    // must be pulse-free at the previous level; the checkpoint edge carries the expectation.
    task automatic run_vec(input int idx, input vec_t v);
        if (v.rst) begin
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            compare_outputs(idx, '0, '0, '0, '0, '0);
            repeat (2) @(posedge clk);
            #1;
            compare_outputs(idx, '0, '0, '0, '0, '0);
            @(negedge clk);
            rst_n = 1'b1;
            prev_lvl = '0;
        end
        raw = v.raw;
        en  = v.en;
        for (int k = 1; k <= v.adv; k++) begin
            @(posedge clk);
            #1;
            if (k < v.adv) compare_outputs(idx, prev_lvl, '0, '0, '0, '0);
            else           compare_outputs(idx, v.lvl, v.prs, v.rel, v.hld, v.hld_nr);
        end
        prev_lvl = v.lvl;
    endtask

    function automatic vec_t mk(input logic [NCH-1:0] r, input logic [NCH-1:0] e, input int a,
                                input logic [NCH-1:0] l, input logic [NCH-1:0] p,
                                input logic [NCH-1:0] rl, input logic [NCH-1:0] h,
                                input logic [NCH-1:0] hn, input bit rs);
        vec_t v;
        v.raw = r; v.en = e; v.adv = a;
        v.lvl = l; v.prs = p; v.rel = rl; v.hld = h; v.hld_nr = hn; v.rst = rs;
        return v;
    endfunction

    initial begin
        // Idle
        vecs.push_back(mk(ALL, ALL, 3, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        // Clean press on ch0: press at edge 6, held at 26, release pin at 30, released at 36
        vecs.push_back(mk(10'h3FE, ALL,  7, 10'h001, 10'h001, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FE, ALL, 20, 10'h001, 10'h000, 10'h000, 10'h001, 10'h001, 0));
        vecs.push_back(mk(10'h3FE, ALL,  3, 10'h001, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  7, 10'h000, 10'h000, 10'h001, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        // Bounce on ch1: press at 11; 2-cycle release glitch freezes hold count, held at 34
        vecs.push_back(mk(10'h3FD, ALL,  3, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  2, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FD, ALL,  6, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FD, ALL,  1, 10'h002, 10'h002, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  2, 10'h002, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FD, ALL, 20, 10'h002, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FD, ALL,  1, 10'h002, 10'h000, 10'h000, 10'h002, 10'h002, 0));
        vecs.push_back(mk(ALL,     ALL,  6, 10'h002, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  1, 10'h000, 10'h000, 10'h002, 10'h000, 10'h000, 0));
        // Long press on ch2: held at 26 on both, repeats at 34..58 only with repeat enabled
        vecs.push_back(mk(10'h3FB, ALL,  7, 10'h004, 10'h004, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3FB, ALL, 20, 10'h004, 10'h000, 10'h000, 10'h004, 10'h004, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(10'h3FB, ALL, 8, 10'h004, 10'h000, 10'h000, 10'h004, 10'h000, 0));
        vecs.push_back(mk(10'h3FB, ALL,  1, 10'h004, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL,  7, 10'h000, 10'h000, 10'h004, 10'h000, 10'h000, 0));
        // Disable / re-enable / async reset on ch3
        vecs.push_back(mk(10'h3F7, ALL,     7, 10'h008, 10'h008, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3F7, 10'h3F7, 1, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3F7, 10'h3F7, 3, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3F7, ALL,     5, 10'h008, 10'h008, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3F7, ALL,     2, 10'h008, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h3F7, ALL,     7, 10'h008, 10'h008, 10'h000, 10'h000, 10'h000, 1));
        vecs.push_back(mk(ALL,     ALL,     7, 10'h000, 10'h000, 10'h008, 10'h000, 10'h000, 0));
        // All channels at once
        vecs.push_back(mk(10'h000, ALL, 7, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(10'h000, ALL, 3, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL, 7, 10'h000, 10'h000, 10'h3FF, 10'h000, 10'h000, 0));
        vecs.push_back(mk(ALL,     ALL, 2, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 0));

        // Power-on reset
        rst_n = 1'b0;
        raw   = ALL;
        en    = ALL;
        #5;
        compare_outputs(-1, '0, '0, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        compare_outputs(-1, '0, '0, '0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_lvl = '0;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
